// File: rtl/updn_counter_pkg.sv
// Shared types and defaults for the limited up/down counter family.
package updn_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RST_LIMIT = 8'hFF;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } op_t;

    // Counter operation priority: load beats count, count beats hold.
    function automatic op_t decode_op(
        input logic ld_cnt_n,
        input logic count_enb,
        input logic updn_cnt
    );
        op_t op;
        op = OP_HOLD;
        if (!ld_cnt_n) begin
            op = OP_LOAD;
        end else if (count_enb) begin
            op = updn_cnt ? OP_UP : OP_DOWN;
        end
        return op;
    endfunction

endpackage

// File: rtl/updn_counter_next.sv
// Combinational next-count and terminal-count computation for one operation.
module updn_counter_next
    import updn_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter bit          SATURATE = 1'b0
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] limit_out,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] next_val,
    output logic             tc_up_nxt,
    output logic             tc_dn_nxt
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    always_comb begin
        next_val  = data_out;
        tc_up_nxt = 1'b0;
        tc_dn_nxt = 1'b0;
        unique case (op)
            OP_LOAD: next_val = data_in;
            // A value loaded above the limit is treated as already at the bound.
            OP_UP: begin
                if (data_out >= limit_out) begin
                    next_val  = SATURATE ? limit_out : ZERO;
                    tc_up_nxt = 1'b1;
                end else begin
                    next_val = data_out + ONE;
                end
            end
            OP_DOWN: begin
                if (data_out == ZERO) begin
                    next_val  = SATURATE ? ZERO : limit_out;
                    tc_dn_nxt = 1'b1;
                end else begin
                    next_val = data_out - ONE;
                end
            end
            default: next_val = data_out;
        endcase
    end

endmodule

// File: rtl/updn_counter_lim.sv
// Registered up/down counter with programmable wrap limit, tc pulses and sticky wrap flag.
// Define UPDN_COUNTER_SVA_EN to compile in the embedded protocol assertions.
module updn_counter_lim
    import updn_counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RST_LIMIT = WIDTH'(DEFAULT_RST_LIMIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_cnt_,
    input  logic             ld_lim_,
    input  logic             updn_cnt,
    input  logic             count_enb,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] limit_out,
    output logic             tc_up,
    output logic             tc_dn,
    output logic             wrap_sticky,
    output logic [1:0]       last_op
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             tc_up_q, tc_up_d;
    logic             tc_dn_q, tc_dn_d;
    logic             sticky_q, sticky_d;
    op_t              last_op_q, last_op_d;

    op_t              op_c;
    logic [WIDTH-1:0] cnt_nxt_c;
    logic             tc_up_nxt_c;
    logic             tc_dn_nxt_c;

    assign op_c = decode_op(ld_cnt_, count_enb, updn_cnt);

    // Count rules see the limit register as it was before any same-cycle limit load.
    updn_counter_next #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next (
        .op        (op_c),
        .data_out  (cnt_q),
        .limit_out (lim_q),
        .data_in   (data_in),
        .next_val  (cnt_nxt_c),
        .tc_up_nxt (tc_up_nxt_c),
        .tc_dn_nxt (tc_dn_nxt_c)
    );

    always_comb begin
        cnt_d     = cnt_nxt_c;
        lim_d     = lim_q;
        tc_up_d   = tc_up_nxt_c;
        tc_dn_d   = tc_dn_nxt_c;
        sticky_d  = sticky_q;
        last_op_d = op_c;
        if (!ld_lim_) begin
            lim_d = data_in;
        end
        // A new wrap event takes precedence over a clear request.
        if (tc_up_nxt_c || tc_dn_nxt_c) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            lim_q     <= RST_LIMIT;
            tc_up_q   <= 1'b0;
            tc_dn_q   <= 1'b0;
            sticky_q  <= 1'b0;
            last_op_q <= OP_HOLD;
        end else begin
            cnt_q     <= cnt_d;
            lim_q     <= lim_d;
            tc_up_q   <= tc_up_d;
            tc_dn_q   <= tc_dn_d;
            sticky_q  <= sticky_d;
            last_op_q <= last_op_d;
        end
    end

    assign data_out    = cnt_q;
    assign limit_out   = lim_q;
    assign tc_up       = tc_up_q;
    assign tc_dn       = tc_dn_q;
    assign wrap_sticky = sticky_q;
    assign last_op     = 2'(last_op_q);

`ifdef UPDN_COUNTER_SVA_EN
    a_reset_zero: assert property (@(posedge clk) disable iff (rst)
        $past(rst) |-> (data_out == '0))
        else $display("SVA reset_zero violated at %0t", $time);

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (ld_cnt_ && !count_enb) |=> $stable(data_out))
        else $display("SVA hold_stable violated at %0t", $time);

    a_up_step: assert property (@(posedge clk) disable iff (rst)
        (ld_cnt_ && count_enb && updn_cnt)
        |=> ((data_out == WIDTH'($past(data_out) + 1'b1)) || tc_up))
        else $display("SVA up_step violated at %0t", $time);

    a_down_step: assert property (@(posedge clk) disable iff (rst)
        (ld_cnt_ && count_enb && !updn_cnt)
        |=> ((data_out == WIDTH'($past(data_out) - 1'b1)) || tc_dn))
        else $display("SVA down_step violated at %0t", $time);

    a_tc_excl: assert property (@(posedge clk) disable iff (rst)
        !(tc_up && tc_dn))
        else $display("SVA tc_excl violated at %0t", $time);

    a_sticky_hold: assert property (@(posedge clk) disable iff (rst)
        $fell(wrap_sticky) |-> ($past(clr_sticky) || $past(rst)))
        else $display("SVA sticky_hold violated at %0t", $time);
`endif

endmodule

// File: tb/tb_updn_counter_lim.sv
// Scoreboard bench for updn_counter_lim: wrap-mode and saturate-mode instances.
module tb_updn_counter_lim;
    import updn_counter_pkg::*;

    typedef struct {
        string       name;
        bit          sat;
        bit          r;
        bit          ldc;
        bit          ldl;
        bit          up;
        bit          en;
        bit          clr;
        logic [7:0]  din;
        logic [20:0] v;
    } step_t;

    typedef struct {
        string       name;
        bit          sat;
        logic [20:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       m_ld_cnt_, m_ld_lim_, m_updn, m_enb, m_clr;
    logic       s_ld_cnt_, s_ld_lim_, s_updn, s_enb, s_clr;

    logic [7:0] m_data, m_lim, s_data, s_lim;
    logic       m_tu, m_td, m_st, s_tu, s_td, s_st;
    logic [1:0] m_op, s_op;
    logic [20:0] obs_m, obs_s;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    updn_counter_lim #(.WIDTH(8), .SATURATE(1'b0), .RST_LIMIT(8'hFF)) dut (
        .clk(clk), .rst(rst), .ld_cnt_(m_ld_cnt_), .ld_lim_(m_ld_lim_),
        .updn_cnt(m_updn), .count_enb(m_enb), .data_in(data_in),
        .clr_sticky(m_clr), .data_out(m_data), .limit_out(m_lim),
        .tc_up(m_tu), .tc_dn(m_td), .wrap_sticky(m_st), .last_op(m_op)
    );

    updn_counter_lim #(.WIDTH(8), .SATURATE(1'b1), .RST_LIMIT(8'hFF)) dut_sat (
        .clk(clk), .rst(rst), .ld_cnt_(s_ld_cnt_), .ld_lim_(s_ld_lim_),
        .updn_cnt(s_updn), .count_enb(s_enb), .data_in(data_in),
        .clr_sticky(s_clr), .data_out(s_data), .limit_out(s_lim),
        .tc_up(s_tu), .tc_dn(s_td), .wrap_sticky(s_st), .last_op(s_op)
    );

    assign obs_m = {m_data, m_lim, m_tu, m_td, m_st, m_op};
    assign obs_s = {s_data, s_lim, s_tu, s_td, s_st, s_op};

    // Expected output vector: data, limit, tc_up, tc_dn, sticky, last_op.
    function automatic logic [20:0] pk(logic [7:0] d, logic [7:0] l, bit tu, bit td,
                                       bit st, op_t op);
        return {d, l, tu, td, st, 2'(op)};
    endfunction

    function automatic step_t mk(string n, bit sat, bit r, bit ldc, bit ldl, bit up,
                                 bit en, bit clr, logic [7:0] din, logic [20:0] v);
        step_t s;
        s.name = n; s.sat = sat; s.r = r; s.ldc = ldc; s.ldl = ldl;
        s.up = up; s.en = en; s.clr = clr; s.din = din; s.v = v;
        return s;
    endfunction

    task automatic drive(input step_t s);
        rst = s.r;
        data_in = s.din;
        m_ld_cnt_ = 1'b1; m_ld_lim_ = 1'b1; m_updn = 1'b1; m_enb = 1'b0; m_clr = 1'b0;
        s_ld_cnt_ = 1'b1; s_ld_lim_ = 1'b1; s_updn = 1'b1; s_enb = 1'b0; s_clr = 1'b0;
        if (s.sat) begin
            s_ld_cnt_ = s.ldc; s_ld_lim_ = s.ldl; s_updn = s.up; s_enb = s.en; s_clr = s.clr;
        end else begin
            m_ld_cnt_ = s.ldc; m_ld_lim_ = s.ldl; m_updn = s.up; m_enb = s.en; m_clr = s.clr;
        end
        sb.push_back('{s.name, s.sat, s.v});
        if (s.r) sb.push_back('{{s.name, "_sat"}, 1'b1, s.v});
    endtask

    task automatic test_reset();
        step_t t[$];
        exp_t e;
        logic [20:0] o;
        t.push_back(mk("rst_a", 0, 1, 0, 0, 1, 1, 0, 8'h5A, pk(8'h00, 8'hFF, 0, 0, 0, OP_HOLD)));
        t.push_back(mk("rst_b", 0, 1, 0, 0, 1, 1, 0, 8'h5A, pk(8'h00, 8'hFF, 0, 0, 0, OP_HOLD)));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = e.sat ? obs_s : obs_m; n_cmp++;
                if (o !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h (data,lim,tu,td,st,op)", e.name, o, e.v);
                end
            end
        end
    endtask

    task automatic test_up_wrap();
        step_t t[$];
        exp_t e;
        logic [20:0] o;
        t.push_back(mk("up_load", 0, 0, 0, 1, 1, 0, 0, 8'hFD, pk(8'hFD, 8'hFF, 0, 0, 0, OP_LOAD)));
        t.push_back(mk("up_fe",   0, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'hFE, 8'hFF, 0, 0, 0, OP_UP)));
        t.push_back(mk("up_ff",   0, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'hFF, 8'hFF, 0, 0, 0, OP_UP)));
        t.push_back(mk("up_wrap", 0, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'h00, 8'hFF, 1, 0, 1, OP_UP)));
        t.push_back(mk("up_01",   0, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'h01, 8'hFF, 0, 0, 1, OP_UP)));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = e.sat ? obs_s : obs_m; n_cmp++;
                if (o !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h (data,lim,tu,td,st,op)", e.name, o, e.v);
                end
            end
        end
    endtask

    task automatic test_down_wrap();
        step_t t[$];
        exp_t e;
        logic [20:0] o;
        t.push_back(mk("dn_lim5",  0, 0, 1, 0, 1, 0, 0, 8'h05, pk(8'h01, 8'h05, 0, 0, 1, OP_HOLD)));
        t.push_back(mk("dn_load0", 0, 0, 0, 1, 1, 0, 0, 8'h00, pk(8'h00, 8'h05, 0, 0, 1, OP_LOAD)));
        t.push_back(mk("dn_wrap",  0, 0, 1, 1, 0, 1, 0, 8'h00, pk(8'h05, 8'h05, 0, 1, 1, OP_DOWN)));
        t.push_back(mk("dn_04",    0, 0, 1, 1, 0, 1, 0, 8'h00, pk(8'h04, 8'h05, 0, 0, 1, OP_DOWN)));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = e.sat ? obs_s : obs_m; n_cmp++;
                if (o !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h (data,lim,tu,td,st,op)", e.name, o, e.v);
                end
            end
        end
    endtask

    task automatic test_limit_bounds();
        step_t t[$];
        exp_t e;
        logic [20:0] o;
        // Same-cycle limit load: the count still uses the old limit 05.
        t.push_back(mk("lb_oldlim",  0, 0, 1, 0, 1, 1, 0, 8'h02, pk(8'h05, 8'h02, 0, 0, 1, OP_UP)));
        t.push_back(mk("lb_above",   0, 0, 1, 1, 1, 1, 1, 8'h00, pk(8'h00, 8'h02, 1, 0, 1, OP_UP)));
        t.push_back(mk("lb_lim0",    0, 0, 1, 0, 1, 0, 0, 8'h00, pk(8'h00, 8'h00, 0, 0, 1, OP_HOLD)));
        t.push_back(mk("lb_up0_a",   0, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'h00, 8'h00, 1, 0, 1, OP_UP)));
        t.push_back(mk("lb_up0_b",   0, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'h00, 8'h00, 1, 0, 1, OP_UP)));
        t.push_back(mk("lb_dn0_a",   0, 0, 1, 1, 0, 1, 0, 8'h00, pk(8'h00, 8'h00, 0, 1, 1, OP_DOWN)));
        t.push_back(mk("lb_dn0_b",   0, 0, 1, 1, 0, 1, 0, 8'h00, pk(8'h00, 8'h00, 0, 1, 1, OP_DOWN)));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = e.sat ? obs_s : obs_m; n_cmp++;
                if (o !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h (data,lim,tu,td,st,op)", e.name, o, e.v);
                end
            end
        end
    endtask

    task automatic test_load_both_hold();
        step_t t[$];
        exp_t e;
        logic [20:0] o;
        t.push_back(mk("lh_both",  0, 0, 0, 0, 1, 0, 0, 8'h10, pk(8'h10, 8'h10, 0, 0, 1, OP_LOAD)));
        t.push_back(mk("lh_hold1", 0, 0, 1, 1, 1, 0, 0, 8'hAA, pk(8'h10, 8'h10, 0, 0, 1, OP_HOLD)));
        t.push_back(mk("lh_hold2", 0, 0, 1, 1, 0, 0, 0, 8'hAA, pk(8'h10, 8'h10, 0, 0, 1, OP_HOLD)));
        t.push_back(mk("lh_hold3", 0, 0, 1, 1, 1, 0, 0, 8'h55, pk(8'h10, 8'h10, 0, 0, 1, OP_HOLD)));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = e.sat ? obs_s : obs_m; n_cmp++;
                if (o !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h (data,lim,tu,td,st,op)", e.name, o, e.v);
                end
            end
        end
    endtask

    task automatic test_saturate();
        step_t t[$];
        exp_t e;
        logic [20:0] o;
        t.push_back(mk("sat_load", 1, 0, 0, 0, 1, 0, 0, 8'h03, pk(8'h03, 8'h03, 0, 0, 0, OP_LOAD)));
        for (int k = 0; k < 3; k++)
            t.push_back(mk("sat_up", 1, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'h03, 8'h03, 1, 0, 1, OP_UP)));
        t.push_back(mk("sat_clr",  1, 0, 1, 1, 1, 0, 1, 8'h00, pk(8'h03, 8'h03, 0, 0, 0, OP_HOLD)));
        t.push_back(mk("sat_ld0",  1, 0, 0, 1, 1, 0, 0, 8'h00, pk(8'h00, 8'h03, 0, 0, 0, OP_LOAD)));
        t.push_back(mk("sat_dn0",  1, 0, 1, 1, 0, 1, 0, 8'h00, pk(8'h00, 8'h03, 0, 1, 1, OP_DOWN)));
        t.push_back(mk("sat_ld9",  1, 0, 0, 1, 1, 0, 0, 8'h09, pk(8'h09, 8'h03, 0, 0, 1, OP_LOAD)));
        t.push_back(mk("sat_up9",  1, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'h03, 8'h03, 1, 0, 1, OP_UP)));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = e.sat ? obs_s : obs_m; n_cmp++;
                if (o !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h (data,lim,tu,td,st,op)", e.name, o, e.v);
                end
            end
        end
    endtask

    task automatic test_reset_mid_count();
        step_t t[$];
        exp_t e;
        logic [20:0] o;
        t.push_back(mk("rm_lim40", 0, 0, 1, 0, 1, 0, 0, 8'h40, pk(8'h10, 8'h40, 0, 0, 1, OP_HOLD)));
        t.push_back(mk("rm_load7", 0, 0, 0, 1, 1, 0, 0, 8'h07, pk(8'h07, 8'h40, 0, 0, 1, OP_LOAD)));
        t.push_back(mk("rm_up8",   0, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'h08, 8'h40, 0, 0, 1, OP_UP)));
        t.push_back(mk("rm_rst",   0, 1, 1, 1, 1, 1, 0, 8'h00, pk(8'h00, 8'hFF, 0, 0, 0, OP_HOLD)));
        t.push_back(mk("rm_up1",   0, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'h01, 8'hFF, 0, 0, 0, OP_UP)));
        t.push_back(mk("rm_up2",   0, 0, 1, 1, 1, 1, 0, 8'h00, pk(8'h02, 8'hFF, 0, 0, 0, OP_UP)));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = e.sat ? obs_s : obs_m; n_cmp++;
                if (o !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h (data,lim,tu,td,st,op)", e.name, o, e.v);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        data_in = 8'h00;
        m_ld_cnt_ = 1'b1; m_ld_lim_ = 1'b1; m_updn = 1'b1; m_enb = 1'b0; m_clr = 1'b0;
        s_ld_cnt_ = 1'b1; s_ld_lim_ = 1'b1; s_updn = 1'b1; s_enb = 1'b0; s_clr = 1'b0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_limit_bounds();
        test_load_both_hold();
        test_saturate();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
